// File: rtl/game_tick_controller_if.sv
// Control pulses in, divider/tick status out, for the game tick controller.
interface game_tick_controller_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             pause;
  logic             collide;
  logic             speed_up;
  logic [WIDTH-1:0] period_max;
  logic [WIDTH-1:0] min_max;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] cur_max;
  logic [WIDTH-1:0] tick_count;
  logic [1:0]       state;

  modport master (
    output start, pause, collide, speed_up, period_max, min_max,
    input  tick, count, cur_max, tick_count, state
  );

  modport slave (
    input  start, pause, collide, speed_up, period_max, min_max,
    output tick, count, cur_max, tick_count, state
  );
endinterface

// File: rtl/game_tick_controller.sv
// Game-step tick generator: programmable divider with speed-up, pause and game-over control.
// Every output is a register; tick pulses in the cycle count has just wrapped to zero.
module game_tick_controller #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(16)
) (
  input logic                   clock,
  input logic                   reset,
  game_tick_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] cur_max_q;
  logic [WIDTH-1:0] tick_count_q;
  logic             tick_q;
  logic             pending_q;

  logic [WIDTH-1:0] start_max;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] next_max;
  logic             pend_eff;

  always_comb begin
    start_max = (bus.period_max > bus.min_max) ? bus.period_max : bus.min_max;
    // Saturate at zero before clamping to the floor so the period never underflows.
    stepped   = (cur_max_q >= STEP) ? (cur_max_q - STEP) : '0;
    next_max  = (stepped > bus.min_max) ? stepped : bus.min_max;
    // A speed-up arriving in the wrap cycle itself is honoured at that wrap.
    pend_eff  = pending_q | bus.speed_up;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      cur_max_q    <= '0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            state_q      <= ST_RUN;
            count_q      <= '0;
            tick_count_q <= '0;
            pending_q    <= 1'b0;
            cur_max_q    <= start_max;
          end
        end
        ST_RUN: begin
          if (bus.collide) begin
            state_q <= ST_OVER;
          end else if (bus.pause) begin
            state_q <= ST_PAUSE;
          end else if (count_q == cur_max_q) begin
            count_q      <= '0;
            tick_q       <= 1'b1;
            tick_count_q <= tick_count_q + WIDTH'(1);
            pending_q    <= 1'b0;
            if (pend_eff) begin
              cur_max_q <= next_max;
            end
          end else begin
            count_q   <= count_q + WIDTH'(1);
            pending_q <= pend_eff;
          end
        end
        ST_PAUSE: begin
          if (bus.collide) begin
            state_q <= ST_OVER;
          end else if (bus.pause) begin
            state_q <= ST_RUN;
          end else if (bus.speed_up) begin
            pending_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.count      = count_q;
  assign bus.cur_max    = cur_max_q;
  assign bus.tick_count = tick_count_q;
  assign bus.tick       = tick_q;

endmodule

// File: tb/tb_game_tick_controller.sv
// Directed scenarios followed by random traffic, all checked each cycle against a behavioural model.
module tb_game_tick_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;

  game_tick_controller_if #(.WIDTH(10)) bus ();
  game_tick_controller_if #(.WIDTH(4))  bus4 ();

  game_tick_controller #(.WIDTH(10), .STEP(10'd16)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  game_tick_controller #(.WIDTH(4), .STEP(4'd2)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4)
  );

  always #5 clock = ~clock;

  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "init";

  // Reference model: mode 0 idle, 1 running, 2 paused, 3 game over.
  int m_mode  = 0;
  int m_count = 0;
  int m_max   = 0;
  int m_tc    = 0;
  bit m_tick  = 0;
  bit m_pend  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_step(input bit rst, input bit st, input bit pa, input bit co,
                            input bit sp, input int pm, input int mn);
    if (rst) begin
      m_mode = 0; m_count = 0; m_max = 0; m_tc = 0; m_tick = 0; m_pend = 0;
      return;
    end
    m_tick = 0;
    if (m_mode == 0 || m_mode == 3) begin
      if (st) begin
        m_mode = 1; m_count = 0; m_tc = 0; m_pend = 0;
        m_max  = (pm > mn) ? pm : mn;
      end
    end else if (co) begin
      m_mode = 3;
    end else if (pa) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else begin
      if (sp) m_pend = 1;
      if (m_mode == 1) begin
        if (m_count < m_max) begin
          m_count++;
        end else begin
          m_count = 0;
          m_tick  = 1;
          m_tc    = (m_tc + 1) % 1024;
          if (m_pend) begin
            m_max = m_max - 16;
            if (m_max < mn) m_max = mn;
            m_pend = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk({phase, ".state"},      int'(bus.state),      m_mode);
    chk({phase, ".count"},      int'(bus.count),      m_count);
    chk({phase, ".cur_max"},    int'(bus.cur_max),    m_max);
    chk({phase, ".tick"},       int'(bus.tick),       int'(m_tick));
    chk({phase, ".tick_count"}, int'(bus.tick_count), m_tc);
  endtask

  task automatic cyc(input bit st = 0, input bit pa = 0, input bit co = 0, input bit sp = 0);
    bus.start    = st;
    bus.pause    = pa;
    bus.collide  = co;
    bus.speed_up = sp;
    @(posedge clock);
    model_step(reset, st, pa, co, sp, int'(bus.period_max), int'(bus.min_max));
    #1;
    compare_all();
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.collide  = 1'b0;
    bus.speed_up = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.collide = 0; bus.speed_up = 0;
    bus.period_max = 10'd4; bus.min_max = 10'd1;
    bus4.start = 0; bus4.pause = 0; bus4.collide = 0; bus4.speed_up = 0;
    bus4.period_max = 4'd0; bus4.min_max = 4'd0;

    // Reset overrides a simultaneous start.
    phase = "reset";
    reset = 1'b1;
    cyc(.st(1));
    chk("reset_state", int'(bus.state), 0);
    reset = 1'b0;

    phase = "basic";
    cyc(.st(1));
    chk("basic_start_count", int'(bus.count), 0);
    run(15);
    chk("basic_tick", int'(bus.tick), 1);
    chk("basic_tick_count", int'(bus.tick_count), 3);
    cyc(.st(1));
    chk("start_in_run_ignored", int'(bus.count), 1);

    phase = "speedup";
    reset = 1'b1; cyc(); reset = 1'b0;
    bus.period_max = 10'd40; bus.min_max = 10'd10;
    cyc(.st(1));
    cyc(.sp(1)); cyc(.sp(1)); cyc(.sp(1));
    run(37);
    chk("speedup_hold_before_wrap", int'(bus.cur_max), 40);
    cyc();
    chk("speedup_24", int'(bus.cur_max), 24);
    chk("speedup_wrap_tick", int'(bus.tick), 1);
    cyc(.sp(1));
    run(23);
    cyc();
    chk("speedup_clamp_10", int'(bus.cur_max), 10);
    cyc(.sp(1));
    run(9);
    cyc();
    chk("speedup_stay_10", int'(bus.cur_max), 10);
    chk("speedup_stay_tick", int'(bus.tick), 1);

    phase = "pause";
    reset = 1'b1; cyc(); reset = 1'b0;
    bus.period_max = 10'd4; bus.min_max = 10'd1;
    cyc(.st(1));
    run(2);
    cyc(.pa(1));
    run(7);
    chk("pause_frozen_count", int'(bus.count), 2);
    chk("pause_state", int'(bus.state), 2);
    cyc(.pa(1));
    run(2);
    cyc();
    chk("resume_wrap_count", int'(bus.count), 0);
    chk("resume_wrap_tick", int'(bus.tick), 1);

    phase = "pause_at_wrap";
    run(4);
    cyc(.pa(1));
    chk("pause_at_wrap_count", int'(bus.count), 4);
    cyc(.pa(1));
    cyc();
    chk("pause_at_wrap_late_tick", int'(bus.tick), 1);

    phase = "collide_wrap";
    run(4);
    cyc(.co(1));
    chk("collide_state", int'(bus.state), 3);
    chk("collide_count", int'(bus.count), 4);
    chk("collide_no_tick", int'(bus.tick), 0);
    run(3);
    cyc(.co(1));
    chk("over_holds", int'(bus.state), 3);
    cyc(.st(1));
    chk("restart_state", int'(bus.state), 1);
    chk("restart_tick_count", int'(bus.tick_count), 0);

    phase = "simultaneous";
    run(2);
    cyc(.co(1), .pa(1), .sp(1));
    chk("simul_over", int'(bus.state), 3);
    chk("simul_count", int'(bus.count), 2);

    phase = "zero_period";
    bus.period_max = 10'd0; bus.min_max = 10'd0;
    cyc(.st(1));
    run(3);
    chk("zero_tick", int'(bus.tick), 1);
    chk("zero_tick_count", int'(bus.tick_count), 3);

    phase = "reset_mid";
    bus.period_max = 10'd4; bus.min_max = 10'd1;
    reset = 1'b1; cyc(); reset = 1'b0;
    cyc(.st(1));
    run(3);
    chk("pre_reset_count", int'(bus.count), 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("reset_mid_state", int'(bus.state), 0);
    chk("reset_mid_count", int'(bus.count), 0);
    cyc();
    chk("reset_after_tick", int'(bus.tick), 0);

    phase = "wrap4";
    bus4.start = 1'b1;
    cyc();
    bus4.start = 1'b0;
    run(15);
    chk("w4_tick_count_15", int'(bus4.tick_count), 15);
    cyc();
    chk("w4_tick_count_wrap", int'(bus4.tick_count), 0);
    chk("w4_tick", int'(bus4.tick), 1);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        bus.period_max = 10'($urandom_range(50));
        bus.min_max    = 10'($urandom_range(30));
      end
      reset = ($urandom_range(999) < 5);
      cyc(.st($urandom_range(99) < 4), .pa($urandom_range(99) < 5),
          .co($urandom_range(99) < 2), .sp($urandom_range(99) < 10));
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_tick_controller.md
GAME_TICK_CONTROLLER -- requirements
Module: game_tick_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, setting the width of all period, count and tick-count vectors.
REQ-002 The block SHALL have parameter STEP, default 10'd16, setting the decrement applied to cur_max per accepted speed-up.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle pulse (pre-debounced) that begins a game.
REQ-006 The block SHALL have port pause, input, 1 bit: single-cycle pulse that toggles RUN/PAUSE.
REQ-007 The block SHALL have port collide, input, 1 bit: level or pulse that ends the game.
REQ-008 The block SHALL have port speed_up, input, 1 bit: single-cycle pulse requesting a shorter tick period.
REQ-009 The block SHALL have port period_max, input, WIDTH bits: initial terminal count loaded at start.
REQ-010 The block SHALL have port min_max, input, WIDTH bits: floor for the terminal count.
REQ-011 The block SHALL have port tick, output, 1 bit: registered one-cycle game-step pulse.
REQ-012 The block SHALL have port count, output, WIDTH bits: current divider value.
REQ-013 The block SHALL have port cur_max, output, WIDTH bits: terminal count in effect.
REQ-014 The block SHALL have port tick_count, output, WIDTH bits: ticks issued since the last start.
REQ-015 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, OVER=11.

Function
REQ-016 In IDLE or OVER, a start pulse SHALL move the FSM to RUN and set count=0, tick_count=0, pending=0, and cur_max=max(period_max, min_max).
REQ-017 In RUN or PAUSE, start SHALL be ignored.
REQ-018 In RUN, count SHALL increment by 1 per cycle while count<cur_max, and SHALL wrap to 0 on the cycle after count==cur_max, giving a period of cur_max+1 cycles.
REQ-019 tick SHALL be 1 exactly in the cycle where count has just wrapped to 0, and 0 in all other cycles.
REQ-020 The first tick after start SHALL occur cur_max+1 cycles after the start cycle.
REQ-021 tick_count SHALL increment on every tick and SHALL wrap from 2^WIDTH-1 to 0.
REQ-022 speed_up in RUN or PAUSE SHALL set a pending flag; multiple pulses before the next wrap SHALL coalesce into one.
REQ-023 At a wrap with pending=1, cur_max SHALL become max(cur_max-STEP, min_max) and pending SHALL clear.
REQ-024 The subtraction SHALL saturate, so that cur_max<STEP yields min_max and never underflows.
REQ-025 cur_max SHALL change only at start or at a wrap, so count never exceeds cur_max.
REQ-026 A pause pulse SHALL move RUN->PAUSE and PAUSE->RUN.
REQ-027 In PAUSE, count and tick_count SHALL be frozen and tick SHALL be 0.
REQ-028 On resume, counting SHALL continue from the frozen count.
REQ-029 collide in RUN or PAUSE SHALL move the FSM to OVER, freeze count, cur_max and tick_count, and suppress tick in that cycle.
REQ-030 collide in IDLE or OVER SHALL be ignored.
REQ-031 OVER SHALL hold until start.
REQ-032 Same-cycle priority SHALL be collide > pause > speed_up.
REQ-033 When collide coincides with count==cur_max, no wrap and no tick SHALL occur.
REQ-034 If pause coincides with count==cur_max in RUN, the FSM SHALL enter PAUSE without wrapping, and the wrap and tick SHALL occur on the first RUN cycle after resume.
REQ-035 period_max=min_max=0 SHALL produce tick on every RUN cycle, with count held at 0.
REQ-036 All outputs SHALL be driven directly from registers.

Reset
REQ-037 reset=1 at a clock edge SHALL force state=IDLE, count=0, cur_max=0, tick=0, tick_count=0 and pending=0, overriding all other inputs including start in the same cycle.
REQ-038 reset asserted mid-RUN or mid-PAUSE SHALL abandon the game, with no tick in the reset cycle or the following cycle.

Verification
REQ-039 The bench SHALL cover basic run: period_max=4, min_max=1, start -> count 0,1,2,3,4,0..., tick high every 5th cycle, tick_count 1,2,3.
REQ-040 The bench SHALL cover speed-up: period_max=40, STEP=16, min_max=10, three speed_up pulses in one period -> cur_max becomes 24 at the next wrap only; after further pulses cur_max sequence is 8 clamped to 10, then stays 10.
REQ-041 The bench SHALL cover pause: pause at count=2 with cur_max=4, hold 7 cycles, then pause again -> count stays 2 with no tick, then resumes 3,4,0 with tick.
REQ-042 The bench SHALL cover collide at wrap: collide in the cycle with count==cur_max -> state=OVER, no tick, count frozen at cur_max; then start -> RUN, count=0, tick_count=0.
REQ-043 The bench SHALL cover simultaneous inputs: collide+pause+speed_up in one cycle -> OVER, pending not applied; start in RUN -> no effect.
REQ-044 The bench SHALL cover reset mid-run: reset during RUN at count=3 -> next cycle all outputs 0 and state=IDLE; tick_count wrap checked with WIDTH=4 (15->0).
